// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vend_ctrl vending-machine controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_e;

  localparam logic [3:0] COIN_1  = 4'b0001;
  localparam logic [3:0] COIN_2  = 4'b0010;
  localparam logic [3:0] COIN_5  = 4'b0100;
  localparam logic [3:0] COIN_10 = 4'b1000;

  // Value of a one-hot coin; anything not exactly one-hot is worth 0.
  function automatic logic [3:0] coin_value(input logic [3:0] coin);
    case (coin)
      COIN_1:  return 4'd1;
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      COIN_10: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  // Largest denomination not exceeding amount; 0 when nothing is owed.
  function automatic logic [3:0] greedy_coin(input logic [31:0] amount);
    if (amount >= 32'd10)     return COIN_10;
    else if (amount >= 32'd5) return COIN_5;
    else if (amount >= 32'd2) return COIN_2;
    else if (amount >= 32'd1) return COIN_1;
    else                      return 4'b0000;
  endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-product inventory counters with vend decrement, restock reload and sold-out flags.
module vend_inventory
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 8,
  parameter int SEL_W        = 3,
  parameter int INV_W        = 3,
  parameter int INV_INIT     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dec_valid,
  input  logic [SEL_W-1:0]        dec_id,
  input  logic                    restock,
  input  logic [SEL_W-1:0]        restock_id,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  logic [INV_W-1:0] inv_q [NUM_PRODUCTS];
  logic [INV_W-1:0] inv_d [NUM_PRODUCTS];

  // Restock beats a same-cycle decrement; an id with no matching slot is ignored.
  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      inv_d[i] = inv_q[i];
      if (restock && (int'(restock_id) == i)) begin
        inv_d[i] = INV_W'(INV_INIT);
      end else if (dec_valid && (int'(dec_id) == i) && (inv_q[i] != '0)) begin
        inv_d[i] = inv_q[i] - INV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        inv_q[i] <= INV_W'(INV_INIT);
      end
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        inv_q[i] <= inv_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_sold
    assign sold_out[g] = (inv_q[g] == '0);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin credit, product vend, greedy change over valid/ready.
// Optional restock ports are enabled by defining VEND_RESTOCK_EN.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 8,
  parameter int SEL_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1,
  parameter int CREDIT_W     = 5,
  parameter int INV_W        = 3,
  parameter int INV_INIT     = 5,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
    {5'd14, 5'd12, 5'd11, 5'd9, 5'd7, 5'd6, 5'd4, 5'd3}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    coin_valid,
  input  logic [3:0]              coin_in,
  input  logic                    select_valid,
  input  logic [SEL_W-1:0]        select_id,
  input  logic                    cancel,
  input  logic                    change_ready,
`ifdef VEND_RESTOCK_EN
  input  logic                    restock,
  input  logic [SEL_W-1:0]        restock_id,
`endif
  output logic [CREDIT_W-1:0]     credit,
  output logic                    vend_valid,
  output logic [SEL_W-1:0]        vend_id,
  output logic                    sel_fail,
  output logic                    coin_reject,
  output logic                    change_valid,
  output logic [3:0]              change_coin,
  output logic [NUM_PRODUCTS-1:0] sold_out,
  output logic                    busy
);

  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]    vend_id_q, vend_id_d;
  logic                sel_fail_q, sel_fail_d;
  logic                coin_reject_q, coin_reject_d;
  logic                change_valid_q, change_valid_d;
  logic [3:0]          change_coin_q, change_coin_d;
  logic                dec_valid;
  logic                restock_s;
  logic [SEL_W-1:0]    restock_id_s;

  logic [CREDIT_W-1:0] price_tbl [NUM_PRODUCTS];
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_range;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] remain;
  logic [CREDIT_W-1:0] change_left;

  for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_price
    assign price_tbl[g] = PRICES[g*CREDIT_W +: CREDIT_W];
  end

`ifdef VEND_RESTOCK_EN
  assign restock_s    = restock;
  assign restock_id_s = restock_id;
`else
  assign restock_s    = 1'b0;
  assign restock_id_s = '0;
`endif

  vend_inventory #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .SEL_W        (SEL_W),
    .INV_W        (INV_W),
    .INV_INIT     (INV_INIT)
  ) u_inventory (
    .clk        (clk),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .dec_id     (vend_id_q),
    .restock    (restock_s),
    .restock_id (restock_id_s),
    .sold_out   (sold_out)
  );

  assign sel_in_range = (int'(select_id) < NUM_PRODUCTS);
  assign sel_price    = sel_in_range ? price_tbl[select_id] : '0;
  assign sel_ok       = sel_in_range && !sold_out[select_id] && (credit_q >= sel_price);
  assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_in));
  assign coin_ok      = (coin_value(coin_in) != 4'd0) && (coin_sum <= CREDIT_MAX);
  assign remain       = credit_q - price_tbl[vend_id_q];
  assign change_left  = credit_q - CREDIT_W'(coin_value(change_coin_q));

  // Change handshake: a coin transfers on a cycle where change_valid and
  // change_ready are both high; while ready is low the offered coin and
  // change_valid hold unchanged, and valid never drops without a transfer.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    vend_valid_d   = 1'b0;
    vend_id_d      = vend_id_q;
    sel_fail_d     = 1'b0;
    coin_reject_d  = 1'b0;
    change_valid_d = change_valid_q;
    change_coin_d  = change_coin_q;
    dec_valid      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (credit_q != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
            change_coin_d  = greedy_coin(32'(credit_q));
          end
        end else if (select_valid) begin
          coin_reject_d = coin_valid;
          if (sel_ok) begin
            state_d      = VEND;
            vend_valid_d = 1'b1;
            vend_id_d    = select_id;
          end else begin
            sel_fail_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_d = coin_valid;
        dec_valid     = 1'b1;
        credit_d      = remain;
        if (remain != '0) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_coin_d  = greedy_coin(32'(remain));
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_valid_q && change_ready) begin
          credit_d = change_left;
          if (change_left == '0) begin
            state_d        = IDLE;
            change_valid_d = 1'b0;
            change_coin_d  = 4'b0000;
          end else begin
            change_coin_d = greedy_coin(32'(change_left));
          end
        end
      end
      default: begin
        state_d        = IDLE;
        change_valid_d = 1'b0;
        change_coin_d  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      vend_valid_q   <= 1'b0;
      vend_id_q      <= '0;
      sel_fail_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 4'b0000;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      vend_valid_q   <= vend_valid_d;
      vend_id_q      <= vend_id_d;
      sel_fail_q     <= sel_fail_d;
      coin_reject_q  <= coin_reject_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
    end
  end

  assign credit       = credit_q;
  assign vend_valid   = vend_valid_q;
  assign vend_id      = vend_id_q;
  assign sel_fail     = sel_fail_q;
  assign coin_reject  = coin_reject_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed steps followed by a randomized phase
// against a transaction-level model of credit, inventory and change.
module tb_vend_ctrl;

  localparam int NP = 8;
  localparam int SW = 3;
  localparam int CW = 5;
  localparam int II = 5;
  localparam int CMAX = 31;

  int price [NP] = '{3, 4, 6, 7, 9, 11, 12, 14};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coin_valid = 1'b0;
  logic [3:0]    coin_in = 4'b0000;
  logic          select_valid = 1'b0;
  logic [SW-1:0] select_id = '0;
  logic          cancel = 1'b0;
  logic          change_ready = 1'b0;
  logic          restock = 1'b0;
  logic [SW-1:0] restock_id = '0;
  logic [CW-1:0] credit;
  logic          vend_valid;
  logic [SW-1:0] vend_id;
  logic          sel_fail;
  logic          coin_reject;
  logic          change_valid;
  logic [3:0]    change_coin;
  logic [NP-1:0] sold_out;
  logic          busy;

  int m_credit;
  int m_inv [NP];
  int n_tests = 0;
  int n_fail = 0;

  vend_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_in      (coin_in),
    .select_valid (select_valid),
    .select_id    (select_id),
    .cancel       (cancel),
    .change_ready (change_ready),
`ifdef VEND_RESTOCK_EN
    .restock      (restock),
    .restock_id   (restock_id),
`endif
    .credit       (credit),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .sel_fail     (sel_fail),
    .coin_reject  (coin_reject),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int coin_val(input logic [3:0] c);
    case (c)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 5;
      4'b1000: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] best_coin(input int amt);
    int denom [4] = '{10, 5, 2, 1};
    logic [3:0] code [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      if (amt >= denom[i]) return code[i];
    end
    return 4'b0000;
  endfunction

  function automatic logic [NP-1:0] exp_sold();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = (m_inv[i] == 0);
    return v;
  endfunction

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < NP; i++) m_inv[i] = II;
  endtask

  task automatic insert_coin(input logic [3:0] c);
    int  v;
    bit  exp_rej;
    v = coin_val(c);
    coin_valid = 1'b1;
    coin_in    = c;
    step();
    coin_valid = 1'b0;
    coin_in    = 4'b0000;
    if (v != 0 && m_credit + v <= CMAX) begin
      m_credit += v;
      exp_rej = 1'b0;
    end else begin
      exp_rej = 1'b1;
    end
    check("coin_reject", coin_reject, exp_rej);
    check("credit_after_coin", credit, m_credit);
    step();
    check("coin_reject_pulse", coin_reject, 0);
  endtask

  task automatic collect_change(input int low_cycles, input bit rnd_ready, input bit rnd_coin);
    int cyc;
    bit rdy;
    bit cv;
    cyc = 0;
    while (m_credit > 0 && cyc < 100) begin
      check("change_valid", change_valid, 1);
      check("change_coin", change_coin, best_coin(m_credit));
      rdy = (cyc >= low_cycles) && (rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
      cv  = rnd_coin && ($urandom_range(0, 3) == 0);
      change_ready = rdy;
      coin_valid   = cv;
      coin_in      = 4'b0001;
      step();
      change_ready = 1'b0;
      coin_valid   = 1'b0;
      coin_in      = 4'b0000;
      check("coin_reject_busy", coin_reject, cv);
      if (rdy) m_credit -= coin_val(best_coin(m_credit));
      cyc++;
    end
    if (cyc >= 100) check("change_timeout", cyc, 0);
    check("change_valid_end", change_valid, 0);
    check("busy_end", busy, 0);
    check("credit_end", credit, m_credit);
  endtask

  task automatic do_select(input int id, input bit with_coin);
    bit ok;
    ok = (m_inv[id] > 0) && (m_credit >= price[id]);
    select_valid = 1'b1;
    select_id    = SW'(id);
    coin_valid   = with_coin;
    coin_in      = 4'b0001;
    step();
    select_valid = 1'b0;
    coin_valid   = 1'b0;
    coin_in      = 4'b0000;
    check("coin_reject_sel", coin_reject, with_coin);
    if (ok) begin
      check("vend_valid", vend_valid, 1);
      check("vend_id", vend_id, id);
      check("sel_fail_ok", sel_fail, 0);
      check("busy_vend", busy, 1);
      m_credit -= price[id];
      m_inv[id]--;
      step();
      check("vend_pulse", vend_valid, 0);
      check("credit_after_vend", credit, m_credit);
      check("sold_out", sold_out, exp_sold());
      if (m_credit > 0) collect_change(0, 1'b1, 1'b1);
      else check("busy_after_vend", busy, 0);
    end else begin
      check("sel_fail", sel_fail, 1);
      check("vend_valid_fail", vend_valid, 0);
      check("credit_kept", credit, m_credit);
      check("busy_fail", busy, 0);
      step();
      check("sel_fail_pulse", sel_fail, 0);
    end
  endtask

  task automatic do_cancel(input int low_cycles, input bit rnd_ready);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    if (m_credit == 0) begin
      check("cancel_noop_valid", change_valid, 0);
      check("cancel_noop_busy", busy, 0);
    end else begin
      collect_change(low_cycles, rnd_ready, 1'b0);
    end
  endtask

  initial begin
    int op;
    int r;
    logic [3:0] c;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit", credit, 0);
    check("rst_vend_valid", vend_valid, 0);
    check("rst_vend_id", vend_id, 0);
    check("rst_sel_fail", sel_fail, 0);
    check("rst_coin_reject", coin_reject, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_change_coin", change_coin, 0);
    check("rst_sold_out", sold_out, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    check("post_rst_busy", busy, 0);

    // Coin 10 + 5, buy product 7 (price 14), one coin of change.
    insert_coin(4'b1000);
    insert_coin(4'b0100);
    do_select(7, 1'b0);

    // Insufficient credit, then refund.
    insert_coin(4'b0010);
    do_select(2, 1'b0);
    do_cancel(0, 1'b0);

    // Drain product 0, then a refused attempt.
    for (int k = 0; k < 5; k++) begin
      insert_coin(4'b0001);
      insert_coin(4'b0010);
      do_select(0, 1'b0);
    end
    check("sold_out0", sold_out[0], 1);
    insert_coin(4'b0001);
    insert_coin(4'b0010);
    do_select(0, 1'b0);
`ifdef VEND_RESTOCK_EN
    restock    = 1'b1;
    restock_id = '0;
    step();
    restock = 1'b0;
    m_inv[0] = II;
    check("sold_out_restock", sold_out, exp_sold());
`endif
    do_cancel(0, 1'b1);
    do_cancel(0, 1'b1);

    // Saturation boundary and malformed coin.
    insert_coin(4'b1000);
    insert_coin(4'b1000);
    insert_coin(4'b1000);
    insert_coin(4'b1000);
    insert_coin(4'b0011);
    insert_coin(4'b0001);
    insert_coin(4'b0001);
    insert_coin(4'b0000);
    do_cancel(0, 1'b1);

    // Select with a same-cycle coin: coin dropped, vend proceeds.
    insert_coin(4'b0100);
    do_select(1, 1'b1);

    // Credit 18 refunded with hopper stalled three cycles.
    insert_coin(4'b1000);
    insert_coin(4'b0100);
    insert_coin(4'b0010);
    insert_coin(4'b0001);
    do_cancel(3, 1'b0);

    // Asynchronous reset in the middle of change.
    insert_coin(4'b1000);
    insert_coin(4'b0001);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("pre_rst_change_valid", change_valid, 1);
    check("pre_rst_change_coin", change_coin, 4'b1000);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_change_valid", change_valid, 0);
    check("async_rst_credit", credit, 0);
    check("async_rst_busy", busy, 0);
    #2;
    reset = 1'b0;
    model_reset();
    step();
    check("after_rst_sold_out", sold_out, exp_sold());
    check("after_rst_busy", busy, 0);
    check("after_rst_credit", credit, 0);

    // Randomized mix of coins, selections and refunds.
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        r = $urandom_range(0, 9);
        if (r < 2) c = 4'($urandom_range(0, 15));
        else       c = 4'b0001 << $urandom_range(0, 3);
        insert_coin(c);
      end else if (op <= 8) begin
        do_select($urandom_range(0, NP - 1), ($urandom_range(0, 3) == 0));
      end else begin
        do_cancel($urandom_range(0, 2), 1'b1);
      end
    end
    do_cancel(0, 1'b1);
    check("final_sold_out", sold_out, exp_sold());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
